// File: rtl/vproc_pkg.sv
// vproc_pkg: shared vector-unit decode types and pending-write tracker defaults.
package vproc_pkg;

    typedef enum logic [1:0] {VSEW_8, VSEW_16, VSEW_32, VSEW_INVALID} cfg_vsew;

    typedef enum logic [1:0] {EMUL_1, EMUL_2, EMUL_4, EMUL_8} cfg_emul;

    typedef enum logic [2:0] {UNIT_LSU, UNIT_ALU, UNIT_MUL, UNIT_SLD, UNIT_ELEM} op_unit;

    typedef struct packed {
        logic store;
        logic cmp;
        logic xreg;
    } op_mode;

    typedef enum logic [1:0] {OP_SINGLEWIDTH, OP_WIDENING, OP_NARROWING, OP_WN_RSVD} op_widenarrow;

    typedef struct packed {
        logic       vreg;
        logic [4:0] addr;
    } op_regd;

    localparam int unsigned PENDWR_CNT_W_DEFAULT = 2;

endpackage

// File: rtl/vproc_wr_mask_dec.sv
// vproc_wr_mask_dec: decodes an issuing instruction into the set of vector registers it writes.
module vproc_wr_mask_dec import vproc_pkg::*; #(
    parameter int unsigned VREG_CNT       = 32,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  cfg_vsew             vsew,
    input  cfg_emul             emul,
    input  op_unit              unit,
    input  op_mode              mode,
    input  op_widenarrow        widenarrow,
    input  op_regd              rd,
    output logic [VREG_CNT-1:0] mask
);

    logic [1:0]  lg;
    logic [4:0]  base;
    logic [31:0] grp;
    logic [31:0] one;
    logic        dc;

    // lg is log2 of the group size; narrowing writes the next-smaller group
    always_comb begin
        lg   = (widenarrow == OP_NARROWING && emul != EMUL_1) ? 2'(emul) - 2'd1 : 2'(emul);
        base = rd.addr & ~((5'd1 << lg) - 5'd1);
        grp  = ((32'd1 << (32'd1 << lg)) - 32'd1) << base;
        one  = 32'd1 << rd.addr;
        dc   = vsew == VSEW_INVALID || widenarrow == OP_WN_RSVD ||
               !(unit inside {UNIT_LSU, UNIT_ALU, UNIT_MUL, UNIT_SLD, UNIT_ELEM});
        mask = !rd.vreg                          ? '0 :
               dc                                ? (DONT_CARE_ZERO ? '0 : 'x) :
               (unit == UNIT_LSU  && mode.store) ? '0 :
               (unit == UNIT_ALU  && mode.cmp)   ? one[VREG_CNT-1:0] :
               (unit == UNIT_ELEM && mode.xreg)  ? '0 :
                                                   grp[VREG_CNT-1:0];
    end

endmodule

// File: rtl/vproc_pending_wr_tracker.sv
// vproc_pending_wr_tracker: per-register outstanding vector write counters with N-port retirement.
// Define VPROC_PENDWR_ERR_EN for the sticky underflow flag err_o and its assertion.
module vproc_pending_wr_tracker import vproc_pkg::*; #(
    parameter int unsigned VREG_CNT       = 32,
    parameter int unsigned CLR_PORTS      = 4,
    parameter int unsigned CNT_W          = PENDWR_CNT_W_DEFAULT,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                               clk_i,
    input  logic                               sync_rst_ni,
    input  logic                               issue_valid_i,
    output logic                               issue_ready_o,
    input  cfg_vsew                            issue_vsew_i,
    input  cfg_emul                            issue_emul_i,
    input  op_unit                             issue_unit_i,
    input  op_mode                             issue_mode_i,
    input  op_widenarrow                       issue_widenarrow_i,
    input  op_regd                             issue_rd_i,
    input  logic [CLR_PORTS-1:0]               clr_valid_i,
    input  logic [CLR_PORTS-1:0][VREG_CNT-1:0] clr_mask_i,
    input  logic [VREG_CNT-1:0]                query_mask_i,
    output logic                               query_hit_o,
    output logic [VREG_CNT-1:0]                pending_wr_o,
    output logic                               err_o
);

    localparam int unsigned DW = $clog2(CLR_PORTS + 1);
    localparam int unsigned SW = (CNT_W + 1 > DW) ? CNT_W + 1 : DW;

    logic [VREG_CNT-1:0] mask;
    logic [VREG_CNT-1:0] sat;
    logic [VREG_CNT-1:0] uflow;
    logic [CNT_W-1:0]    cnt     [VREG_CNT];
    logic [CNT_W-1:0]    cnt_nxt [VREG_CNT];
    logic                accept;

    vproc_wr_mask_dec #(
        .VREG_CNT       (VREG_CNT),
        .DONT_CARE_ZERO (DONT_CARE_ZERO)
    ) mask_dec (
        .vsew       (issue_vsew_i),
        .emul       (issue_emul_i),
        .unit       (issue_unit_i),
        .mode       (issue_mode_i),
        .widenarrow (issue_widenarrow_i),
        .rd         (issue_rd_i),
        .mask       (mask)
    );

    // back-pressure looks only at registered counts, so same-cycle clears never free a slot
    assign issue_ready_o = ~|(mask & sat);
    assign accept        = issue_valid_i & issue_ready_o;
    assign query_hit_o   = |(query_mask_i & pending_wr_o);

    for (genvar r = 0; r < VREG_CNT; r++) begin : g_reg
        logic [SW-1:0] sum;
        logic [SW-1:0] dec;
        always_comb begin
            sum = SW'(cnt[r]) + SW'(accept & mask[r]);
            dec = '0;
            for (int p = 0; p < CLR_PORTS; p++) dec = dec + SW'(clr_valid_i[p] & clr_mask_i[p][r]);
        end
        assign sat[r]     = &cnt[r];
        assign uflow[r]   = dec > sum;
        assign cnt_nxt[r] = uflow[r] ? '0 : CNT_W'(sum - dec);
    end

    always_ff @(posedge clk_i) begin
        for (int r = 0; r < VREG_CNT; r++) begin
            cnt[r]          <= sync_rst_ni ? cnt_nxt[r] : '0;
            pending_wr_o[r] <= sync_rst_ni & (|cnt_nxt[r]);
        end
    end

`ifdef VPROC_PENDWR_ERR_EN
    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            err_o <= 1'b0;
        end else begin
            err_o <= err_o | (|uflow);
            assert (~|uflow) else $error("pending write counter underflow");
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vproc_pending_wr_tracker.sv
// tb_vproc_pending_wr_tracker: directed scoreboard bench for the pending vector write tracker.
module tb_vproc_pending_wr_tracker;
    import vproc_pkg::*;

`ifdef VPROC_PENDWR_ERR_EN
    localparam logic UF_ERR = 1'b1;
`else
    localparam logic UF_ERR = 1'b0;
`endif

    typedef struct packed {
        int          cyc;
        logic [95:0] name;
        logic [31:0] pend;
        logic        rdy;
        logic        hit;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_valid;
    logic              issue_ready;
    cfg_vsew           issue_vsew;
    cfg_emul           issue_emul;
    op_unit            issue_unit;
    op_mode            issue_mode;
    op_widenarrow      issue_widenarrow;
    op_regd            issue_rd;
    logic [3:0]        clr_valid;
    logic [3:0][31:0]  clr_mask;
    logic [31:0]       query_mask;
    logic              query_hit;
    logic [31:0]       pending_wr;
    logic              err;

    exp_t        q[$];
    exp_t        e;
    logic [34:0] act;
    logic [34:0] req;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    vproc_pending_wr_tracker dut (
        .clk_i              (clk),
        .sync_rst_ni        (rst_n),
        .issue_valid_i      (issue_valid),
        .issue_ready_o      (issue_ready),
        .issue_vsew_i       (issue_vsew),
        .issue_emul_i       (issue_emul),
        .issue_unit_i       (issue_unit),
        .issue_mode_i       (issue_mode),
        .issue_widenarrow_i (issue_widenarrow),
        .issue_rd_i         (issue_rd),
        .clr_valid_i        (clr_valid),
        .clr_mask_i         (clr_mask),
        .query_mask_i       (query_mask),
        .query_hit_o        (query_hit),
        .pending_wr_o       (pending_wr),
        .err_o              (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e   = q.pop_front();
            act = {pending_wr, issue_ready, query_hit, err};
            req = {e.pend, e.rdy, e.hit, e.err};
            n_chk++;
            if (e.cyc == cyc && act === req) n_pass++;
            else $display("FAIL %0s: got pend=%h rdy=%b hit=%b err=%b, want pend=%h rdy=%b hit=%b err=%b (cycle %0d, due %0d)",
                          e.name, pending_wr, issue_ready, query_hit, err, e.pend, e.rdy, e.hit, e.err, cyc, e.cyc);
        end
    end

    task automatic idle();
        issue_valid      = 1'b0;
        issue_vsew       = VSEW_32;
        issue_emul       = EMUL_1;
        issue_unit       = UNIT_ALU;
        issue_mode       = '0;
        issue_widenarrow = OP_SINGLEWIDTH;
        issue_rd         = '{vreg: 1'b1, addr: 5'd0};
        clr_valid        = '0;
        clr_mask         = '0;
        query_mask       = '1;
    endtask

    task automatic iss(input cfg_emul em, input logic [4:0] a);
        issue_valid = 1'b1;
        issue_emul  = em;
        issue_rd    = '{vreg: 1'b1, addr: a};
    endtask

    task automatic clr(input int p, input logic [31:0] m);
        clr_valid[p] = 1'b1;
        clr_mask[p]  = m;
    endtask

    task automatic exp_out(input logic [95:0] nm, input logic [31:0] pd, input logic r, input logic h, input logic er);
        q.push_back(exp_t'{cyc: cyc, name: nm, pend: pd, rdy: r, hit: h, err: er});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        iss(EMUL_4, 5'd9); exp_out("reset_hold", 32'h0, 1, 0, 0); tick();
        n_chk++;
        if (pending_wr === 32'h0 && issue_ready === 1'b1) n_pass++;
        else $display("FAIL reset_direct: pend=%h rdy=%b", pending_wr, issue_ready);
        n_chk++;
        if (query_hit === 1'b0) n_pass++;
        else $display("FAIL reset_hit: hit=%b", query_hit);
        rst_n = 1'b1;
        iss(EMUL_4, 5'd9); exp_out("reset_state", 32'h0, 1, 0, 0); tick();
        clr(2, 32'hF00);   exp_out("emul4_v9", 32'hF00, 1, 1, 0); tick();
        exp_out("clr_p2", 32'h0, 1, 0, 0); tick();
        iss(EMUL_1, 5'd3); exp_out("v3_inc1", 32'h0, 1, 0, 0); tick();
        iss(EMUL_1, 5'd3); exp_out("v3_inc2", 32'h8, 1, 1, 0); tick();
        iss(EMUL_1, 5'd3); exp_out("v3_inc3", 32'h8, 1, 1, 0); tick();
        iss(EMUL_1, 5'd3); exp_out("v3_full", 32'h8, 0, 1, 0); tick();
        iss(EMUL_1, 5'd4); exp_out("v4_ready", 32'h8, 1, 1, 0); tick();
        iss(EMUL_1, 5'd3); clr(0, 32'h8); exp_out("v3_nocredit", 32'h18, 0, 1, 0); tick();
        iss(EMUL_1, 5'd3); exp_out("v3_ready", 32'h18, 1, 1, 0); tick();
        clr(0, 32'h18); clr(1, 32'h8); clr(2, 32'h8); query_mask = 32'h10;
        exp_out("multi_clr", 32'h18, 1, 1, 0); tick();
        exp_out("clr_all", 32'h0, 1, 0, 0); tick();
        iss(EMUL_1, 5'd5); exp_out("v5_pre", 32'h0, 1, 0, 0); tick();
        iss(EMUL_1, 5'd5); clr(3, 32'h20); exp_out("v5_issue", 32'h20, 1, 1, 0); tick();
        iss(EMUL_1, 5'd5); exp_out("v5_net", 32'h20, 1, 1, 0); tick();
        clr(0, 32'h20); clr(1, 32'h20); exp_out("v5_two_clr", 32'h20, 1, 1, 0); tick();
        exp_out("v5_dual_clr", 32'h0, 1, 0, 0); tick();
        iss(EMUL_2, 5'd6); issue_widenarrow = OP_NARROWING; query_mask = 32'h80;
        exp_out("narrow_pre", 32'h0, 1, 0, 0); tick();
        iss(EMUL_8, 5'd8); issue_mode.cmp = 1'b1; query_mask = 32'h80;
        exp_out("narrow_v6", 32'h40, 1, 0, 0); tick();
        query_mask = 32'h280; exp_out("cmp_v8", 32'h140, 1, 0, 0); tick();
        iss(EMUL_1, 5'd10); issue_rd.vreg = 1'b0; exp_out("novreg_pre", 32'h140, 1, 1, 0); tick();
        iss(EMUL_1, 5'd11); issue_unit = UNIT_ELEM; issue_mode.xreg = 1'b1;
        exp_out("novreg", 32'h140, 1, 1, 0); tick();
        clr(1, 32'h80); exp_out("elem_xreg", 32'h140, 1, 1, 0); tick();
        exp_out("uflow_v7", 32'h140, 1, 1, UF_ERR); tick();
        rst_n = 1'b0; exp_out("err_sticky", 32'h140, 1, 1, UF_ERR); tick();
        rst_n = 1'b1; exp_out("mid_reset", 32'h0, 1, 0, 0); tick();
        iss(EMUL_8, 5'd17); issue_unit = UNIT_MUL; exp_out("emul8_pre", 32'h0, 1, 0, 0); tick();
        iss(EMUL_2, 5'd7); exp_out("emul8_v17", 32'h00FF_0000, 1, 1, 0); tick();
        iss(EMUL_1, 5'd0); exp_out("emul2_v7", 32'h00FF_00C0, 1, 1, 0); tick();
        iss(EMUL_1, 5'd0); exp_out("v0_inc1", 32'h00FF_00C1, 1, 1, 0); tick();
        iss(EMUL_1, 5'd0); exp_out("v0_inc2", 32'h00FF_00C1, 1, 1, 0); tick();
        iss(EMUL_1, 5'd0); issue_unit = UNIT_LSU; issue_mode.store = 1'b1;
        exp_out("store_ready", 32'h00FF_00C1, 1, 1, 0); tick();
        iss(EMUL_1, 5'd0); exp_out("v0_full", 32'h00FF_00C1, 0, 1, 0); tick();
        repeat (2) tick();
        while (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            $display("FAIL %0s: never compared, want pend=%h", e.name, e.pend);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
